// File: rtl/axi4_slv_pkg.sv
// Shared types and burst address helpers for the AXI4 burst slave.
// Addresses are handled 64 bits wide here; callers truncate to their bus width.
package axi4_slv_pkg;

    typedef logic [63:0] addr64_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    localparam int PAGE_BITS = 12;

    function automatic addr64_t next_addr(input addr64_t addr, input logic [2:0] size,
                                          input logic [7:0] len, input burst_e burst);
        addr64_t inc;
        addr64_t mask;
        inc  = 64'd1 << size;
        mask = ((addr64_t'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + inc) & mask);
            default:     next_addr = addr + inc;
        endcase
    endfunction

    // Whole-burst legality; per-beat range checks are done by the caller.
    function automatic logic burst_legal(input addr64_t addr, input logic [2:0] size,
                                         input logic [7:0] len, input burst_e burst,
                                         input logic [2:0] max_size, input logic wrap_en);
        addr64_t last_byte;
        last_byte   = addr + ((addr64_t'(len) + 64'd1) << size) - 64'd1;
        burst_legal = (size <= max_size);
        case (burst)
            BURST_INCR: begin
                if ((last_byte >> PAGE_BITS) != (addr >> PAGE_BITS))
                    burst_legal = 1'b0;
            end
            BURST_WRAP: begin
                if (!wrap_en)
                    burst_legal = 1'b0;
                if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
                    burst_legal = 1'b0;
                if ((addr & ((64'd1 << size) - 64'd1)) != 64'd0)
                    burst_legal = 1'b0;
            end
            BURST_RSVD: burst_legal = 1'b0;
            default: ;
        endcase
    endfunction

endpackage

// File: rtl/axi4_slv_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one read port with 1-cycle latency.
// A same-cycle read of a word being written returns the old contents.
module axi4_slv_ram
    import axi4_slv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b])
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi4_burst_slave.sv
// AXI4 scratch-memory slave with independent read and write burst FSMs on a dual-port RAM.
// Define AXI4_SLV_WRAP_EN to support WRAP bursts; otherwise WRAP is answered with SLVERR.
module axi4_burst_slave
    import axi4_slv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int ID_WIDTH     = 4,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_BITS  = $clog2(STRB_WIDTH);
    localparam int RAM_AW     = $clog2(MEMORY_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(LANE_BITS);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

`ifdef AXI4_SLV_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    w_state_e              w_state, w_state_nx;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_idx;
    logic [7:0]            w_len, w_beat;
    logic [2:0]            w_size;
    burst_e                w_burst;
    logic                  w_bad, w_err, w_beat_ok, aw_legal;

    r_state_e              r_state, r_state_nx;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_idx;
    logic [7:0]            r_len, r_beat;
    logic [2:0]            r_size;
    burst_e                r_burst;
    logic                  r_bad, r_beat_ok, ar_legal, ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign w_idx     = w_addr >> LANE_BITS;
    assign r_idx     = r_addr >> LANE_BITS;
    assign w_beat_ok = !w_bad && ({1'b0, w_idx} < DEPTH_LIMIT);
    assign aw_legal  = burst_legal(addr64_t'(AWADDR), AWSIZE, AWLEN, burst_e'(AWBURST),
                                   MAX_SIZE, WRAP_EN);
    assign ar_legal  = burst_legal(addr64_t'(ARADDR), ARSIZE, ARLEN, burst_e'(ARBURST),
                                   MAX_SIZE, WRAP_EN);

    axi4_slv_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEMORY_DEPTH)) u_ram (
        .clk   (ACLK),
        .we    (WVALID && WREADY && w_beat_ok),
        .waddr (w_idx[RAM_AW-1:0]),
        .wstrb (WSTRB),
        .wdata (WDATA),
        .re    (ram_re),
        .raddr (r_idx[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID)
                    w_state_nx = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && (w_beat == w_len))
                    w_state_nx = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY)
                    w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // The beat counter alone ends the burst; WLAST only feeds the error flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= BURST_FIXED;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
            w_beat  <= '0;
        end else begin
            if (AWVALID && AWREADY) begin
                w_id    <= AWID;
                w_addr  <= AWADDR;
                w_len   <= AWLEN;
                w_size  <= AWSIZE;
                w_burst <= burst_e'(AWBURST);
                w_bad   <= !aw_legal;
                w_err   <= 1'b0;
                w_beat  <= '0;
            end
            if (WVALID && WREADY) begin
                w_addr <= ADDR_WIDTH'(next_addr(addr64_t'(w_addr), w_size, w_len, w_burst));
                w_beat <= w_beat + 8'd1;
                if (!w_beat_ok || (WLAST != (w_beat == w_len)))
                    w_err <= 1'b1;
            end
        end
    end

    assign BID   = BVALID ? w_id : '0;
    assign BRESP = (BVALID && w_err) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        r_state_nx = r_state;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        ram_re     = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID)
                    r_state_nx = R_FETCH;
            end
            R_FETCH: begin
                ram_re     = 1'b1;
                r_state_nx = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY)
                    r_state_nx = (r_beat == r_len) ? R_IDLE : R_FETCH;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Beat legality is latched alongside the RAM fetch so it lines up with ram_rdata.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= BURST_FIXED;
            r_bad     <= 1'b0;
            r_beat    <= '0;
            r_beat_ok <= 1'b0;
        end else begin
            if (ARVALID && ARREADY) begin
                r_id    <= ARID;
                r_addr  <= ARADDR;
                r_len   <= ARLEN;
                r_size  <= ARSIZE;
                r_burst <= burst_e'(ARBURST);
                r_bad   <= !ar_legal;
                r_beat  <= '0;
            end
            if (r_state == R_FETCH)
                r_beat_ok <= !r_bad && ({1'b0, r_idx} < DEPTH_LIMIT);
            if (RVALID && RREADY) begin
                r_addr <= ADDR_WIDTH'(next_addr(addr64_t'(r_addr), r_size, r_len, r_burst));
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    assign RID   = RVALID ? r_id : '0;
    assign RDATA = (RVALID && r_beat_ok) ? ram_rdata : '0;
    assign RRESP = (RVALID && !r_beat_ok) ? RESP_SLVERR : RESP_OKAY;
    assign RLAST = RVALID && (r_beat == r_len);

endmodule

// File: tb/tb_axi4_burst_slave.sv
// Scoreboard bench for axi4_burst_slave: expected B and R results are queued when a burst
// is issued and checked as the slave returns them; a byte-level memory model supplies read data.
module tb_axi4_burst_slave;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_beat_t;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model [0:1023];
    r_beat_t     r_exp[$];
    logic [5:0]  b_exp[$];
    r_beat_t     r_got;
    logic [5:0]  b_got;

    always #5 ACLK = ~ACLK;

    axi4_burst_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] tb_next(input logic [15:0] a, input logic [15:0] start,
                                            input int len, input logic [1:0] burst);
        int blk, base, off;
        if (burst == 2'b00)
            return a;
        if (burst == 2'b10) begin
            blk  = (len + 1) * 4;
            base = int'(start) - (int'(start) % blk);
            off  = (int'(a) - base + 4) % blk;
            return 16'(base + off);
        end
        return a + 16'd4;
    endfunction

    // Responses are popped one half-cycle before the handshake edge.
    always @(negedge ACLK) begin
        if (ARESETn && RVALID && RREADY) begin
            if (r_exp.size() == 0) begin
                checkOutput("r_unexpected", 64'd1, 64'd0);
            end else begin
                r_got = r_exp.pop_front();
                checkOutput("rid", 64'(RID), 64'(r_got.id));
                checkOutput("rdata", 64'(RDATA), 64'(r_got.data));
                checkOutput("rresp", 64'(RRESP), 64'(r_got.resp));
                checkOutput("rlast", 64'(RLAST), 64'(r_got.last));
            end
        end
        if (ARESETn && BVALID && BREADY) begin
            if (b_exp.size() == 0) begin
                checkOutput("b_unexpected", 64'd1, 64'd0);
            end else begin
                b_got = b_exp.pop_front();
                checkOutput("bid", 64'(BID), 64'(b_got[5:2]));
                checkOutput("bresp", 64'(BRESP), 64'(b_got[1:0]));
            end
        end
    end

    task automatic applyStimulusWrite(input logic [3:0] id, input logic [15:0] addr,
                                      input int len, input logic [1:0] burst,
                                      input logic [31:0] data0, input logic [3:0] strb,
                                      input int last_beat, input logic [1:0] exp_resp,
                                      input bit lands);
        logic [15:0] a;
        logic [31:0] wd;
        int          cnt;
        bit          hs;
        a = addr;
        b_exp.push_back({id, exp_resp});
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'd2; AWBURST = burst;
        AWVALID = 1'b1;
        cnt = 0;
        do begin
            @(negedge ACLK); hs = AWREADY; @(posedge ACLK); cnt++;
        end while (!hs && cnt < 20);
        #1 AWVALID = 1'b0;
        checkOutput("aw_wait", 64'(cnt), 64'd1);
        for (int b = 0; b <= len; b++) begin
            wd = data0 + 32'(b) * 32'h0101_0101;
            WDATA = wd; WSTRB = strb; WLAST = (b == last_beat); WVALID = 1'b1;
            cnt = 0;
            do begin
                @(negedge ACLK); hs = WREADY; @(posedge ACLK); cnt++;
            end while (!hs && cnt < 20);
            #1;
            if (!hs) begin
                checkOutput("w_timeout", 64'd1, 64'd0);
                break;
            end
            if (lands)
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[a[11:2]][k*8 +: 8] = wd[k*8 +: 8];
            a = tb_next(a, addr, len, burst);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        cnt = 0;
        while (b_exp.size() != 0 && cnt < 50) begin
            @(negedge ACLK); cnt++;
        end
        if (b_exp.size() != 0) begin
            checkOutput("b_timeout", 64'd1, 64'd0);
            b_exp.delete();
        end
        @(posedge ACLK); #1;
    endtask

    task automatic applyStimulusRead(input logic [3:0] id, input logic [15:0] addr,
                                     input int len, input logic [1:0] burst, input bit ok);
        logic [15:0] a;
        r_beat_t     e;
        int          cnt;
        bit          hs;
        a = addr;
        for (int b = 0; b <= len; b++) begin
            e.id   = id;
            e.last = (b == len);
            e.resp = ok ? 2'b00 : 2'b10;
            e.data = ok ? model[a[11:2]] : 32'h0;
            r_exp.push_back(e);
            a = tb_next(a, addr, len, burst);
        end
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'd2; ARBURST = burst;
        ARVALID = 1'b1;
        cnt = 0;
        do begin
            @(negedge ACLK); hs = ARREADY; @(posedge ACLK); cnt++;
        end while (!hs && cnt < 20);
        #1 ARVALID = 1'b0;
        checkOutput("ar_wait", 64'(cnt), 64'd1);
        @(negedge ACLK);
        checkOutput("r_lat_t1", 64'(RVALID), 64'd0);
        @(negedge ACLK);
        checkOutput("r_lat_t2", 64'(RVALID), 64'd1);
        @(posedge ACLK); #1;
    endtask

    task automatic waitReads();
        int cnt;
        cnt = 0;
        while (r_exp.size() != 0 && cnt < 200) begin
            @(negedge ACLK); cnt++;
        end
        if (r_exp.size() != 0) begin
            checkOutput("r_timeout", 64'd1, 64'd0);
            r_exp.delete();
        end
        @(posedge ACLK); #1;
    endtask

    task automatic readBurst(input logic [3:0] id, input logic [15:0] addr, input int len,
                             input logic [1:0] burst, input bit ok);
        applyStimulusRead(id, addr, len, burst, ok);
        waitReads();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] held;
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("rst_awready", 64'(AWREADY), 64'd1);
        checkOutput("rst_arready", 64'(ARREADY), 64'd1);
        checkOutput("rst_wready", 64'(WREADY), 64'd0);
        checkOutput("rst_bvalid", 64'(BVALID), 64'd0);
        checkOutput("rst_rvalid", 64'(RVALID), 64'd0);
        checkOutput("rst_rdata", 64'(RDATA), 64'd0);
        checkOutput("rst_rlast", 64'(RLAST), 64'd0);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        applyStimulusWrite(4'h1, 16'h0000, 0, 2'b01, 32'h0BAD_F00D, 4'hF, 0, 2'b00, 1'b1);
        applyStimulusWrite(4'h1, 16'h0010, 3, 2'b01, 32'h1122_3344, 4'hF, 3, 2'b00, 1'b1);
        readBurst(4'h2, 16'h0010, 3, 2'b01, 1'b1);

        applyStimulusWrite(4'h3, 16'h0010, 0, 2'b01, 32'hAABB_CCDD, 4'b0101, 0, 2'b00, 1'b1);
        readBurst(4'h3, 16'h0010, 0, 2'b01, 1'b1);

        applyStimulusWrite(4'h4, 16'h0030, 3, 2'b01, 32'hC0DE_0001, 4'hF, 3, 2'b00, 1'b1);
`ifdef AXI4_SLV_WRAP_EN
        readBurst(4'h4, 16'h0038, 3, 2'b10, 1'b1);
`else
        readBurst(4'h4, 16'h0038, 3, 2'b10, 1'b0);
`endif

        applyStimulusWrite(4'h5, 16'h1000, 0, 2'b01, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, 1'b0);
        readBurst(4'h5, 16'h0000, 0, 2'b01, 1'b1);
        readBurst(4'h5, 16'h1000, 0, 2'b01, 1'b0);

        applyStimulusWrite(4'h6, 16'h0FFC, 0, 2'b01, 32'h600D_CAFE, 4'hF, 0, 2'b00, 1'b1);
        applyStimulusWrite(4'h6, 16'h0FFC, 1, 2'b01, 32'h1234_5678, 4'hF, 1, 2'b10, 1'b0);
        readBurst(4'h6, 16'h0FFC, 0, 2'b01, 1'b1);
        readBurst(4'h6, 16'h0FFC, 1, 2'b01, 1'b0);

        applyStimulusWrite(4'h7, 16'h0040, 3, 2'b01, 32'h4040_4040, 4'hF, 1, 2'b10, 1'b1);
        readBurst(4'h7, 16'h0040, 3, 2'b01, 1'b1);
        applyStimulusWrite(4'h8, 16'h0050, 1, 2'b01, 32'h5050_5050, 4'hF, 99, 2'b10, 1'b1);
        applyStimulusWrite(4'h8, 16'h0060, 2, 2'b00, 32'h6060_6060, 4'hF, 2, 2'b00, 1'b1);
        readBurst(4'h8, 16'h0060, 1, 2'b00, 1'b1);

        RREADY = 1'b0;
        held = model[4];
        applyStimulusRead(4'h7, 16'h0010, 1, 2'b01, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checkOutput("stall_rvalid", 64'(RVALID), 64'd1);
            checkOutput("stall_rdata", 64'(RDATA), 64'(held));
            checkOutput("stall_rlast", 64'(RLAST), 64'd0);
            checkOutput("stall_rid", 64'(RID), 64'h7);
        end
        @(posedge ACLK); #1;
        applyStimulusWrite(4'h2, 16'h0010, 0, 2'b01, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 1'b1);
        @(negedge ACLK);
        checkOutput("stall_rdata_after_wr", 64'(RDATA), 64'(held));
        @(posedge ACLK); #1;
        RREADY = 1'b1;
        waitReads();

        fork
            applyStimulusWrite(4'h3, 16'h0080, 3, 2'b01, 32'h8080_8080, 4'hF, 3, 2'b00, 1'b1);
            readBurst(4'h5, 16'h0010, 3, 2'b01, 1'b1);
        join
        readBurst(4'h9, 16'h0080, 3, 2'b01, 1'b1);

        RREADY = 1'b0;
        AWID = 4'h9; AWADDR = 16'h0200; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
        ARID = 4'h4; ARADDR = 16'h0010; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
        AWVALID = 1'b1; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; ARVALID = 1'b0;
        WDATA = 32'h1212_1212; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b0;
        #1;
        checkOutput("abort_awready", 64'(AWREADY), 64'd1);
        checkOutput("abort_arready", 64'(ARREADY), 64'd1);
        checkOutput("abort_wready", 64'(WREADY), 64'd0);
        checkOutput("abort_bvalid", 64'(BVALID), 64'd0);
        checkOutput("abort_rvalid", 64'(RVALID), 64'd0);
        checkOutput("abort_rdata", 64'(RDATA), 64'd0);
        checkOutput("abort_rid", 64'(RID), 64'd0);
        WVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        readBurst(4'hA, 16'h0010, 0, 2'b01, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
